sum_window_accumulator: RTL

Downstream stage of the registered 4-bit operand adder. It consumes the adder's 8-bit sum stream under a valid/ready handshake and accumulates a fixed window of COUNT samples. For each window it presents the total and the peak sample, holding them until the consumer takes them. Sits between the adder and the reporting/debug logic.

---
 rtl/sum_acc_pkg.sv | 32 +++
 rtl/sum_window_accumulator_max.sv | 34 +++
 rtl/sum_window_accumulator.sv | 108 ++++++++++
 3 files changed

// File: rtl/sum_acc_pkg.sv
// Shared types and helpers for the sum window accumulator.
// No logic: the state enum, a constant-evaluable clog2, and a parameter legality check.
// Used at elaboration time by the top module.
package sum_acc_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    // Ceiling log2 for values >= 1, written as a bounded loop so it folds to a constant.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // A legal set keeps the counter exactly as wide as the window index and the
    // accumulator wide enough that a full window of maximum samples cannot wrap.
    function automatic bit params_legal(input int data_w, input int count,
                                        input int cnt_w, input int acc_w);
        return (count >= 2) && (count <= 256) &&
               (cnt_w == clog2(count)) &&
               (acc_w >= data_w + cnt_w);
    endfunction

endpackage

// File: rtl/sum_window_accumulator_max.sv
// Running unsigned maximum of the samples accepted in the current window.
// Latency: peak is combinational on the current sample; run_max updates one cycle after a sample.
// Backpressure: none of its own; the parent only asserts sample_en on an accepted sample.
module window_max_tracker #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sample_en,
    input  logic [DATA_W-1:0] sample,
    input  logic              restart,
    input  logic              clear,
    output logic [DATA_W-1:0] peak
);

    logic [DATA_W-1:0] run_max;

    // Max of the window so far including the sample on the input this cycle.
    always_comb begin
        peak = (sample > run_max) ? sample : run_max;
    end

    // run_max restarts at window completion or on a flush, otherwise follows accepted samples.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            run_max <= '0;
        end else if (clear || restart) begin
            run_max <= '0;
        end else if (sample_en) begin
            run_max <= peak;
        end
    end

endmodule

// File: rtl/sum_window_accumulator.sv
// Accumulates COUNT sum samples per window and presents total and peak until taken.
// Latency: out_valid rises the cycle after the last sample of a window is accepted.
// Backpressure: in_ready drops while a result is held, stalling upstream until out_ready.
module sum_window_accumulator
    import sum_acc_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int COUNT  = 4,
    parameter int CNT_W  = 2,
    parameter int ACC_W  = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    input  logic              clear,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic [DATA_W-1:0] out_max
);

    if (!params_legal(DATA_W, COUNT, CNT_W, ACC_W)) begin : g_param_check
        $error("sum_window_accumulator: illegal DATA_W/COUNT/CNT_W/ACC_W combination");
    end

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(COUNT - 1);

    state_t            state;
    state_t            state_next;
    logic [ACC_W-1:0]  acc;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] peak;
    logic              take;
    logic              last;

    // A flush wins over a sample presented in the same cycle.
    assign take = in_valid && in_ready && !clear;
    assign last = take && (cnt == LAST_IDX);

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ACCUM;
        end else begin
            state <= state_next;
        end
    end

    // Next state: window completion enters HOLD; handshake or flush leaves it.
    always_comb begin
        state_next = state;
        case (state)
            ACCUM: begin
                if (last) begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (clear || out_ready) begin
                    state_next = ACCUM;
                end
            end
            default: state_next = ACCUM;
        endcase
    end

    // Handshake outputs decode the state register only, so no path runs from in_valid or out_ready.
    always_comb begin
        in_ready  = (state == ACCUM);
        out_valid = (state == HOLD);
    end

    // Accumulator, sample counter and result registers; results keep their value across a flush.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc     <= '0;
            cnt     <= '0;
            out_sum <= '0;
            out_max <= '0;
        end else if (clear) begin
            acc <= '0;
            cnt <= '0;
        end else if (last) begin
            out_sum <= acc + ACC_W'(in_data);
            out_max <= peak;
            acc     <= '0;
            cnt     <= '0;
        end else if (take) begin
            acc <= acc + ACC_W'(in_data);
            cnt <= cnt + CNT_W'(1);
        end
    end

    window_max_tracker #(
        .DATA_W (DATA_W)
    ) u_max (
        .clk       (clk),
        .rst_n     (rst_n),
        .sample_en (take),
        .sample    (in_data),
        .restart   (last),
        .clear     (clear),
        .peak      (peak)
    );

endmodule
